inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction queue between the fetch stage and the decode stage. Buffers fetched instruction words with their PC and fetch-exception flag, then presents one entry per cycle to the decoders, which consume `inst[31:0]`. It absorbs fetch latency and decode stalls, and is emptied in one cycle on a pipeline flush (branch mispredict or exception).

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all entries and any push in the same cycle.
- `push_valid`  in  1  fetch offers an entry.
- `push_ready`  out  1  queue can accept an entry; equals `count < DEPTH`.
- `push_inst`  in  32  instruction word.
- `push_pc`  in  32  virtual address of the instruction.
- `push_exc`  in  1  fetch raised an address or TLB exception for this entry.
- `pop_valid`  out  1  head entry is valid for decode.
- `pop_ready`  in  1  decode consumes the head this cycle.
- `pop_inst`  out  32  head instruction; 32'h0 (NOP) when `pop_valid=0`.
- `pop_pc`  out  32  head PC; 32'h0 when `pop_valid=0`.
- `pop_exc`  out  1  head exception flag; 0 when `pop_valid=0`.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer. The read pointer `rp` and write pointer `wp` are each $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. `count` is kept as an explicit register.
- A push fires when `push_valid && push_ready && !flush`. The entry is written at `wp`, and `wp` increments.
- A pop fires when `pop_valid && pop_ready && !flush`, and `rp` increments.
- When a push and a pop fire in the same cycle, `count` is unchanged. This is legal both at `count=1` and at `count=DEPTH-1`.
- At `count=DEPTH`, `push_ready=0`, even if a pop fires in the same cycle. Ready depends only on registered state, so there is no combinational ready path from `pop_ready`.
- Flush has top priority:
  - It sets `rp=wp=0` and `count=0` on the next edge.
  - During the flush cycle, `pop_valid` is forced to 0 and push/pop do not fire.
  - `push_ready` is not gated by flush.
- Reset clears the same state as flush. Storage contents are not cleared.
- `pop_valid = (count != 0) && !flush`, plus the bypass path when the bypass feature is enabled (see Configuration).
- The exception flag travels unchanged with its instruction. The queue does not interpret the flag.

## Timing
- Reset values: `push_ready=1`, `pop_valid=0`, `pop_inst=0`, `pop_pc=0`, `pop_exc=0`, `count=0`.
- Latency without bypass:
  - An entry pushed on edge N is visible on `pop_*` in the cycle after edge N.
  - Throughput is 1 entry per cycle in steady state.
- `pop_*` comes combinationally from the storage entry at `rp` (a mux) and holds stable while `pop_ready=0`.
- Reset or flush asserted mid-burst: the next cycle shows `count=0` and `pop_valid=0`. A push in the cycle after that is accepted normally.
- Simultaneous `rst` and `flush`: identical result, no conflict.

## Configuration
- `CPU_IFQ_BYPASS_EN`, when defined:
  - When `count=0 && push_valid && !flush`, the `pop_*` outputs are driven directly from `push_*` in the same cycle.
  - If `pop_ready=1` in that cycle, the entry is consumed and never written to storage; `count` stays 0 and the pointers stay unchanged.
  - If `pop_ready=0`, the entry is written normally.
  - This gives zero-cycle latency on an empty queue. The cost is a combinational path from `push_*` to `pop_*`.
- When not defined: `pop_valid` depends on `count` and `flush` only, with a minimum latency of 1 cycle. There is no combinational path from `push_*` to `pop_*`.

## Test plan
- Reset, then push {inst=32'h3C01_1234, pc=32'hBFC0_0000}, {32'h3421_5678, 32'hBFC0_0004} with `pop_ready=0` -> `count=2`, `pop_inst=32'h3C01_1234`; then raise `pop_ready` for 2 cycles -> entries pop in order, then `pop_valid=0` and `pop_inst=0`.
- Hold `pop_ready=0` and push 5 entries (DEPTH=4) -> `push_ready=0` after the 4th push, the 5th is held by fetch, `count=4`; pop one -> `push_ready=1` the next cycle and the 5th entry is accepted.
- Continuous push and pop for 10 cycles from `count=1` -> `count` stays 1, PCs come out in increasing order, and `rp` wraps past index 3 correctly.
- With `count=3`, assert `flush` together with `push_valid=1` and `pop_ready=1` -> `pop_valid=0` in that cycle, `count=0` next cycle, and the pushed entry is absent.
- Push {inst=0, pc=32'h8000_0001, exc=1} -> it pops with `pop_exc=1` and `pc=32'h8000_0001`, and the following entry pops with `exc=0`.
- Bypass path on an empty queue with `push_valid=1` and `pop_ready=1`:
  - `CPU_IFQ_BYPASS_EN` defined -> `pop_valid=1` in the same cycle and `count` stays 0.
  - `CPU_IFQ_BYPASS_EN` undefined -> `pop_valid=0` in that cycle, then 1 in the next cycle.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode: circular buffer of {inst, pc, exc}.
// Optional same-cycle bypass on an empty queue when CPU_IFQ_BYPASS_EN is defined.
module inst_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [31:0]            push_inst,
    input  logic [31:0]            push_pc,
    input  logic                   push_exc,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [31:0]            pop_inst,
    output logic [31:0]            pop_pc,
    output logic                   pop_exc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic          mem_exc  [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;

    logic bypass;
    logic byp_take;
    logic push_fire;
    logic pop_fire;
    logic wr_en;
    logic rd_en;

`ifdef CPU_IFQ_BYPASS_EN
    assign bypass = (count == '0) && push_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Ready looks only at registered occupancy, never at pop_ready.
    assign push_ready = (count != FULL);
    assign pop_valid  = ((count != '0) || bypass) && !flush;
    assign push_fire  = push_valid && push_ready && !flush;
    assign pop_fire   = pop_valid && pop_ready && !flush;

    // A bypassed entry that decode takes immediately never touches storage.
    assign byp_take = bypass && pop_ready;
    assign wr_en    = push_fire && !byp_take;
    assign rd_en    = pop_fire && !byp_take;

    always_comb begin
        pop_inst = 32'h0;
        pop_pc   = 32'h0;
        pop_exc  = 1'b0;
        if (pop_valid) begin
            if (bypass) begin
                pop_inst = push_inst;
                pop_pc   = push_pc;
                pop_exc  = push_exc;
            end else begin
                pop_inst = mem_inst[rp];
                pop_pc   = mem_pc[rp];
                pop_exc  = mem_exc[rp];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_inst[wp] <= push_inst;
            mem_pc[wp]   <= push_pc;
            mem_exc[wp]  <= push_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4), both bypass builds.
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, flush, push_valid, push_exc, pop_ready;
    logic [31:0] push_inst, push_pc;
    logic        push_ready, pop_valid, pop_exc;
    logic [31:0] pop_inst, pop_pc;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    inst_fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_inst(push_inst), .push_pc(push_pc), .push_exc(push_exc),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_inst(pop_inst), .pop_pc(pop_pc), .pop_exc(pop_exc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic pv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic exc, input logic pr, input logic fl);
        push_valid = pv;
        push_inst  = inst;
        push_pc    = pc;
        push_exc   = exc;
        pop_ready  = pr;
        flush      = fl;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepClock();
        stepClock();
        checkOutput("rst_push_ready", 32'(push_ready), 32'd1);
        checkOutput("rst_pop_valid", 32'(pop_valid), 32'd0);
        checkOutput("rst_pop_inst", pop_inst, 32'h0);
        checkOutput("rst_pop_pc", pop_pc, 32'h0);
        checkOutput("rst_pop_exc", 32'(pop_exc), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        rst = 1'b0;

        // Two pushes with decode stalled, then drain in order.
        applyStimulus(1, 32'h3C01_1234, 32'hBFC0_0000, 0, 0, 0);
        stepClock();
        applyStimulus(1, 32'h3421_5678, 32'hBFC0_0004, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_count2", 32'(count), 32'd2);
        checkOutput("t1_head_inst", pop_inst, 32'h3C01_1234);
        checkOutput("t1_head_pc", pop_pc, 32'hBFC0_0000);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t1_pop0_inst", pop_inst, 32'h3C01_1234);
        stepClock();
        checkOutput("t1_pop1_inst", pop_inst, 32'h3421_5678);
        checkOutput("t1_pop1_pc", pop_pc, 32'hBFC0_0004);
        stepClock();
        checkOutput("t1_empty_valid", 32'(pop_valid), 32'd0);
        checkOutput("t1_empty_inst", pop_inst, 32'h0);
        checkOutput("t1_empty_count", 32'(count), 32'd0);

        // Fill to DEPTH; fifth entry waits until a pop frees a slot.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 0, 0, 0);
            checkOutput("t2_ready_fill", 32'(push_ready), 32'd1);
            stepClock();
        end
        applyStimulus(1, 32'h1004, 32'h110, 0, 0, 0);
        checkOutput("t2_full_ready", 32'(push_ready), 32'd0);
        checkOutput("t2_full_count", 32'(count), 32'd4);
        stepClock();
        checkOutput("t2_held_count", 32'(count), 32'd4);
        applyStimulus(1, 32'h1004, 32'h110, 0, 1, 0);
        checkOutput("t2_full_pop_ready", 32'(push_ready), 32'd0);
        checkOutput("t2_pop_pc", pop_pc, 32'h100);
        stepClock();
        applyStimulus(1, 32'h1004, 32'h110, 0, 0, 0);
        checkOutput("t2_ready_after_pop", 32'(push_ready), 32'd1);
        checkOutput("t2_count3", 32'(count), 32'd3);
        stepClock();
        checkOutput("t2_count4_again", 32'(count), 32'd4);
        applyStimulus(0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 5; i++) begin
            checkOutput("t2_drain_pc", pop_pc, 32'h100 + 32'(4 * i));
            stepClock();
        end
        checkOutput("t2_drained", 32'(count), 32'd0);

        // Steady push+pop from count=1 across pointer wrap.
        applyStimulus(1, 32'h2000, 32'h200, 0, 0, 0);
        stepClock();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'h2001 + 32'(i), 32'h204 + 32'(4 * i), 0, 1, 0);
            checkOutput("t3_stream_pc", pop_pc, 32'h200 + 32'(4 * i));
            checkOutput("t3_stream_count", 32'(count), 32'd1);
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t3_last_pc", pop_pc, 32'h228);
        checkOutput("t3_last_inst", pop_inst, 32'h200A);
        stepClock();
        checkOutput("t3_drained", 32'(count), 32'd0);

        // Flush with count=3 while pushing and popping.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h3000 + 32'(i), 32'h300 + 32'(4 * i), 0, 0, 0);
            stepClock();
        end
        checkOutput("t4_count3", 32'(count), 32'd3);
        applyStimulus(1, 32'h3FFF, 32'h3FC, 0, 1, 1);
        checkOutput("t4_flush_valid", 32'(pop_valid), 32'd0);
        checkOutput("t4_flush_ready", 32'(push_ready), 32'd1);
        checkOutput("t4_flush_inst", pop_inst, 32'h0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_post_count", 32'(count), 32'd0);
        checkOutput("t4_post_valid", 32'(pop_valid), 32'd0);
        applyStimulus(1, 32'h4000, 32'h400, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_new_count", 32'(count), 32'd1);
        checkOutput("t4_new_pc", pop_pc, 32'h400);
        applyStimulus(0, 0, 0, 0, 1, 0);
        stepClock();

        // Exception flag travels with its entry.
        applyStimulus(1, 32'h0, 32'h8000_0001, 1, 0, 0);
        stepClock();
        applyStimulus(1, 32'h1111_1111, 32'h8000_0005, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t5_exc1", 32'(pop_exc), 32'd1);
        checkOutput("t5_exc_pc", pop_pc, 32'h8000_0001);
        checkOutput("t5_exc_inst", pop_inst, 32'h0);
        checkOutput("t5_exc_valid", 32'(pop_valid), 32'd1);
        stepClock();
        checkOutput("t5_exc0", 32'(pop_exc), 32'd0);
        checkOutput("t5_next_pc", pop_pc, 32'h8000_0005);
        stepClock();
        checkOutput("t5_drained", 32'(count), 32'd0);

        // Empty queue, push and pop offered together.
        applyStimulus(1, 32'hABCD, 32'h500, 0, 1, 0);
`ifdef CPU_IFQ_BYPASS_EN
        checkOutput("t6_byp_valid", 32'(pop_valid), 32'd1);
        checkOutput("t6_byp_pc", pop_pc, 32'h500);
        checkOutput("t6_byp_inst", pop_inst, 32'hABCD);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_byp_count", 32'(count), 32'd0);
        checkOutput("t6_byp_after", 32'(pop_valid), 32'd0);
`else
        checkOutput("t6_nobyp_valid", 32'(pop_valid), 32'd0);
        checkOutput("t6_nobyp_inst", pop_inst, 32'h0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_nobyp_next", 32'(pop_valid), 32'd1);
        checkOutput("t6_nobyp_pc", pop_pc, 32'h500);
        checkOutput("t6_nobyp_count", 32'(count), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        stepClock();
        checkOutput("t6_nobyp_drained", 32'(count), 32'd0);
`endif

        // Reset mid-burst, then reset together with flush.
        applyStimulus(1, 32'h6000, 32'h600, 0, 0, 0);
        stepClock();
        applyStimulus(1, 32'h6001, 32'h604, 0, 0, 0);
        stepClock();
        rst = 1'b1;
        applyStimulus(1, 32'h6002, 32'h608, 0, 0, 0);
        stepClock();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t7_rst_count", 32'(count), 32'd0);
        checkOutput("t7_rst_valid", 32'(pop_valid), 32'd0);
        applyStimulus(1, 32'h7000, 32'h700, 0, 0, 0);
        stepClock();
        rst = 1'b1;
        applyStimulus(1, 32'h7001, 32'h704, 0, 0, 1);
        stepClock();
        rst = 1'b0;
        applyStimulus(1, 32'h7002, 32'h708, 1, 0, 0);
        checkOutput("t7_rstfl_count", 32'(count), 32'd0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t7_accept_count", 32'(count), 32'd1);
        checkOutput("t7_accept_pc", pop_pc, 32'h708);
        checkOutput("t7_accept_exc", 32'(pop_exc), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
